// File: rtl/sdf_pkg.sv
// Shared definitions for the SDF FFT butterfly stages: default widths,
// stage-control encodings and a complex sample type.
package sdf_pkg;

  localparam int SDF_DW   = 24;
  localparam int SDF_FRAC = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BF   = 2'd1,
    ST_TW   = 2'd2,
    ST_ILL  = 2'd3
  } sdf_state_e;

  typedef struct packed {
    logic signed [SDF_DW-1:0] re;
    logic signed [SDF_DW-1:0] im;
  } sdf_cplx_t;

endpackage

// File: rtl/sdf_cmult.sv
// Combinational complex multiplier p = a * w with FRAC-bit fixed-point scaling.
// Macro SDF_ROUND_EN: round half up before the shift; otherwise floor.
module sdf_cmult
  import sdf_pkg::*;
#(
  parameter int DW   = SDF_DW,
  parameter int FRAC = SDF_FRAC
) (
  input  logic [DW-1:0] a_r_i,
  input  logic [DW-1:0] a_i_i,
  input  logic [DW-1:0] w_r_i,
  input  logic [DW-1:0] w_i_i,
  output logic [DW-1:0] p_r_o,
  output logic [DW-1:0] p_i_o
);

  localparam int PW = 2 * DW + 1;

`ifdef SDF_ROUND_EN
  localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif

  logic signed [PW-1:0] ar_x, ai_x, wr_x, wi_x;
  logic signed [PW-1:0] re_full, im_full;

  // Operands are widened to full product precision so the sum cannot overflow.
  assign ar_x = {{(DW+1){a_r_i[DW-1]}}, a_r_i};
  assign ai_x = {{(DW+1){a_i_i[DW-1]}}, a_i_i};
  assign wr_x = {{(DW+1){w_r_i[DW-1]}}, w_r_i};
  assign wi_x = {{(DW+1){w_i_i[DW-1]}}, w_i_i};

  assign re_full = ar_x * wr_x - ai_x * wi_x + RND;
  assign im_full = ar_x * wi_x + ai_x * wr_x + RND;

  assign p_r_o = DW'(re_full >>> FRAC);
  assign p_i_o = DW'(im_full >>> FRAC);

endmodule

// File: rtl/sdf_bf_stage_4.sv
// Radix-2 single-path delay-feedback butterfly stage, 4-deep feedback line.
// Fill / butterfly / twiddle behaviour is selected by the ROM-driven state.
// Macro SDF_ROUND_EN (in sdf_cmult) selects rounding of the twiddle product.
module sdf_bf_stage_4
  import sdf_pkg::*;
#(
  parameter int DW    = SDF_DW,
  parameter int DEPTH = 4,
  parameter int FRAC  = SDF_FRAC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] din_r,
  input  logic [DW-1:0] din_i,
  input  logic [1:0]    state,
  input  logic [DW-1:0] w_r,
  input  logic [DW-1:0] w_i,
  output logic          out_valid,
  output logic [DW-1:0] dout_r,
  output logic [DW-1:0] dout_i
);

  // Entry 0 is the head (oldest), entry DEPTH-1 is the tail.
  logic [DW-1:0] dl_r_q [DEPTH];
  logic [DW-1:0] dl_i_q [DEPTH];
  logic [DW-1:0] dl_r_d [DEPTH];
  logic [DW-1:0] dl_i_d [DEPTH];

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] dout_r_q, dout_r_d;
  logic [DW-1:0] dout_i_q, dout_i_d;

  logic [DW-1:0] rot_r, rot_i;
  logic          shift_en;
  logic [DW-1:0] push_r, push_i;

  sdf_cmult #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_cmult (
    .a_r_i (dl_r_q[0]),
    .a_i_i (dl_i_q[0]),
    .w_r_i (w_r),
    .w_i_i (w_i),
    .p_r_o (rot_r),
    .p_i_o (rot_i)
  );

  // Per-state output selection and delay-line push value.
  always_comb begin
    shift_en    = 1'b0;
    push_r      = '0;
    push_i      = '0;
    out_valid_d = 1'b0;
    dout_r_d    = dout_r_q;
    dout_i_d    = dout_i_q;
    case (sdf_state_e'(state))
      ST_FILL: begin
        shift_en = in_valid;
        push_r   = din_r;
        push_i   = din_i;
      end
      ST_BF: begin
        if (in_valid) begin
          shift_en    = 1'b1;
          push_r      = dl_r_q[0] - din_r;
          push_i      = dl_i_q[0] - din_i;
          dout_r_d    = dl_r_q[0] + din_r;
          dout_i_d    = dl_i_q[0] + din_i;
          out_valid_d = 1'b1;
        end
      end
      ST_TW: begin
        // Zeros are pushed when input stops so the stream tail drains.
        shift_en    = 1'b1;
        push_r      = in_valid ? din_r : '0;
        push_i      = in_valid ? din_i : '0;
        dout_r_d    = rot_r;
        dout_i_d    = rot_i;
        out_valid_d = 1'b1;
      end
      default: begin
        shift_en = 1'b0;
      end
    endcase
  end

  // Delay-line next state: hold, or drop head and append at tail.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      dl_r_d[i] = dl_r_q[i];
      dl_i_d[i] = dl_i_q[i];
    end
    if (shift_en) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        dl_r_d[i] = dl_r_q[i+1];
        dl_i_d[i] = dl_i_q[i+1];
      end
      dl_r_d[DEPTH-1] = push_r;
      dl_i_d[DEPTH-1] = push_i;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dl_r_q[i] <= '0;
        dl_i_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      dout_r_q    <= '0;
      dout_i_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dl_r_q[i] <= dl_r_d[i];
        dl_i_q[i] <= dl_i_d[i];
      end
      out_valid_q <= out_valid_d;
      dout_r_q    <= dout_r_d;
      dout_i_q    <= dout_i_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout_r    = dout_r_q;
  assign dout_i    = dout_i_q;

endmodule

// File: tb/tb_sdf_bf_stage_4.sv
// Directed self-checking bench for sdf_bf_stage_4.
module tb_sdf_bf_stage_4;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] din_r, din_i, w_r, w_i;
  logic [1:0]    state;
  logic          out_valid;
  logic [DW-1:0] dout_r, dout_i;

  int checks   = 0;
  int failures = 0;

  // 4-point twiddles exp(-j*2*pi*k/8) scaled by 256
  int tw_r [4] = '{256, 181, 0, -181};
  int tw_i [4] = '{0, -181, -256, -181};

  always #5 clk = ~clk;

  sdf_bf_stage_4 #(.DW(24), .DEPTH(4), .FRAC(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .state     (state),
    .w_r       (w_r),
    .w_i       (w_i),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  // Apply one input cycle; outputs for it are visible on return.
  task automatic step(input logic v, input logic [1:0] st, input int dr, input int di,
                      input int wr, input int wi);
    in_valid = v;
    state    = st;
    din_r    = DW'(dr);
    din_i    = DW'(di);
    w_r      = DW'(wr);
    w_i      = DW'(wi);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 2'd0, 0, 0, 0, 0);
    step(1'b0, 2'd0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++)
      step(1'b1, 2'd1, int'($urandom_range(1, 1000)), int'($urandom_range(1, 1000)), 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    checks++;
    if (dout_r !== 24'd0 || dout_i !== 24'd0) begin
      failures++; $display("FAIL reset_dout got (%0d,%0d) exp (0,0)", $signed(dout_r), $signed(dout_i));
    end
    rst_n = 1'b1;
    step(1'b1, 2'd1, 5, 3, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || dout_r !== 24'd5 || dout_i !== 24'd3) begin
      failures++;
      $display("FAIL reset_first_sum got v=%b (%0d,%0d) exp v=1 (5,3)", out_valid, $signed(dout_r), $signed(dout_i));
    end
  endtask

  task automatic test_ramp();
    int sum_exp [4] = '{1536, 2048, 2560, 3072};
    int rot_r   [4] = '{-1024, -724, 0, 724};
    int rot_i   [4] = '{0, 724, 1024, 724};
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 2'd0, 256 * k, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL ramp_fill_valid k=%0d got %b exp 0", k, out_valid);
      end
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 2'd1, 256 * (j + 5), 0, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || dout_r !== DW'(sum_exp[j]) || dout_i !== 24'd0) begin
        failures++;
        $display("FAIL ramp_sum j=%0d got v=%b (%0d,%0d) exp v=1 (%0d,0)", j, out_valid,
                 $signed(dout_r), $signed(dout_i), sum_exp[j]);
      end
    end
    // Twiddle phase overlapped with the next frame's fill
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 2'd2, 100 * (j + 1), 0, tw_r[j], tw_i[j]);
      checks++;
      if (out_valid !== 1'b1 || dout_r !== DW'(rot_r[j]) || dout_i !== DW'(rot_i[j])) begin
        failures++;
        $display("FAIL ramp_rot j=%0d got v=%b (%0d,%0d) exp v=1 (%0d,%0d)", j, out_valid,
                 $signed(dout_r), $signed(dout_i), rot_r[j], rot_i[j]);
      end
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 2'd1, 10 * (j + 1), 0, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || dout_r !== DW'(110 * (j + 1))) begin
        failures++;
        $display("FAIL ramp_next_sum j=%0d got v=%b %0d exp v=1 %0d", j, out_valid,
                 $signed(dout_r), 110 * (j + 1));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(1'b1, 2'd0, 10, 0, 0, 0);
    step(1'b1, 2'd0, 20, 0, 0, 0);
    // Illegal state: no shift, no output
    step(1'b1, 2'd3, 999, 999, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL illegal_valid got %b exp 0", out_valid);
    end
    step(1'b1, 2'd0, 30, 0, 0, 0);
    step(1'b1, 2'd0, 40, 0, 0, 0);
    step(1'b1, 2'd1, 1, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || dout_r !== 24'd11) begin
      failures++; $display("FAIL stall_sum0 got v=%b %0d exp v=1 11", out_valid, $signed(dout_r));
    end
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 2'd1, 777, 777, 0, 0);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL stall_gap s=%0d got %b exp 0", s, out_valid);
      end
    end
    for (int j = 2; j <= 4; j++) begin
      step(1'b1, 2'd1, j, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || dout_r !== DW'(11 * j)) begin
        failures++; $display("FAIL stall_sum j=%0d got v=%b %0d exp v=1 %0d", j, out_valid, $signed(dout_r), 11 * j);
      end
    end
    for (int j = 1; j <= 4; j++) begin
      step(1'b0, 2'd2, 0, 0, 256, 0);
      checks++;
      if (out_valid !== 1'b1 || dout_r !== DW'(9 * j) || dout_i !== 24'd0) begin
        failures++;
        $display("FAIL stall_diff j=%0d got v=%b (%0d,%0d) exp v=1 (%0d,0)", j, out_valid,
                 $signed(dout_r), $signed(dout_i), 9 * j);
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, 2'd0, 256 * k, 0, 0, 0);
    for (int k = 5; k <= 8; k++) step(1'b1, 2'd1, 256 * k, 0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 2'd2, 555, 555, tw_r[j], tw_i[j]);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL drain_valid j=%0d got %b exp 1", j, out_valid);
      end
    end
    for (int j = 0; j < 4; j++) begin
      step(1'b1, 2'd1, 7 + j, 0, 0, 0);
      checks++;
      if (out_valid !== 1'b1 || dout_r !== DW'(7 + j) || dout_i !== 24'd0) begin
        failures++;
        $display("FAIL drain_zero_sum j=%0d got v=%b (%0d,%0d) exp v=1 (%0d,0)", j, out_valid,
                 $signed(dout_r), $signed(dout_i), 7 + j);
      end
    end
  endtask

  task automatic test_rounding();
    int exp_r;
`ifdef SDF_ROUND_EN
    exp_r = 3;
`else
    exp_r = 2;
`endif
    do_reset();
    step(1'b1, 2'd0, 4, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1'b1, 2'd0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1'b1, 2'd1, 0, 0, 0, 0);
    step(1'b0, 2'd2, 0, 0, 181, -181);
    checks++;
    if (out_valid !== 1'b1 || dout_r !== DW'(exp_r) || dout_i !== DW'(-3)) begin
      failures++;
      $display("FAIL rounding got v=%b (%0d,%0d) exp v=1 (%0d,-3)", out_valid,
               $signed(dout_r), $signed(dout_i), exp_r);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    step(1'b1, 2'd0, 'h7FFFFF, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(1'b1, 2'd0, 0, 0, 0, 0);
    step(1'b1, 2'd1, 1, 0, 0, 0);
    checks++;
    if (out_valid !== 1'b1 || dout_r !== 24'h800000) begin
      failures++; $display("FAIL overflow_sum got v=%b %h exp v=1 800000", out_valid, dout_r);
    end
    for (int k = 0; k < 3; k++) step(1'b1, 2'd1, 0, 0, 0, 0);
    step(1'b0, 2'd2, 0, 0, 256, 0);
    checks++;
    if (out_valid !== 1'b1 || dout_r !== 24'h7FFFFE || dout_i !== 24'd0) begin
      failures++; $display("FAIL overflow_diff got v=%b %h/%h exp v=1 7ffffe/000000", out_valid, dout_r, dout_i);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    state    = 2'd0;
    din_r    = '0;
    din_i    = '0;
    w_r      = '0;
    w_i      = '0;
    test_reset();
    test_ramp();
    test_stall();
    test_drain();
    test_rounding();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
